vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose
//   Generates VGA raster timing: pixel/line counters plus active-low
//   horizontal/vertical sync, a visible-region flag and a start-of-frame
//   pulse. The defaults give 640x480 @ 60 Hz (800 x 525 total) from a
//   25.175 MHz pixel clock.
//
// Configuration
//   VGA_TIMING_CLKDIV2_EN : when defined, an internal toggle advances the
//                           counters on every second clk cycle so the block
//                           can run straight from a 50 MHz clock. The first
//                           advance happens on the second clk edge after
//                           reset release. When undefined, the counters
//                           advance on every clk edge and no divider exists.
//
// Ports
//   clk         in   pixel clock (or 2x pixel clock with the divider)
//   rst_n       in   asynchronous, active-low reset
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   bright      out  high while (hcount, vcount) is inside the visible area
//   hcount      out  current pixel column [9:0]
//   vcount      out  current line [9:0]
//   pixel_tick  out  high in each cycle that shows a freshly advanced count
//   frame_start out  one-cycle pulse in the cycle (0,0) first appears
//
// Timing
//   Every output is a flop. The decodes are computed from the next-state
//   counter values, so the registered syncs/bright/frame_start line up with
//   the registered hcount/vcount in the same cycle.
//   Reset parks the counters on the last position (HT-1, VT-1) so the very
//   first advance wraps to (0,0) and raises frame_start.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // tick: the counters advance on the clk edge that ends a cycle with tick=1
  logic tick;

`ifdef VGA_TIMING_CLKDIV2_EN
  // Toggle starts at 0, so edge 1 only sets it and edge 2 is the first advance.
  logic div_q;
  logic div_d;

  always_comb begin
    div_d = ~div_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       bright_q, bright_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    bright_d      = bright_q;
    pixel_tick_d  = tick;
    frame_start_d = 1'b0;

    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end

      // Decode from the values the counters are about to take.
      hsync_d       = ~((hcount_d >= HS_START) && (hcount_d < HS_END));
      vsync_d       = ~((vcount_d >= VS_START) && (vcount_d < VS_END));
      bright_d      = (hcount_d < H_VIS) && (vcount_d < V_VIS);
      frame_start_d = (hcount_d == 10'd0) && (vcount_d == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      bright_q      <= 1'b0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      pixel_tick_q  <= pixel_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign bright      = bright_q;
  assign pixel_tick  = pixel_tick_q;
  assign frame_start = frame_start_q;

endmodule
